dmem_arbiter: RTL
=================

# dmem_arbiter

Arbitrates the single data-cache port between the speculative load path and the committed-store drain from the store buffer. Sits between the memory unit and the data cache. Keeps one request outstanding and holds it stable until the cache responds. Squashes in-flight loads on pipeline flush and prevents store starvation with a bounded load-priority counter.

## Interface
- STARVE_LIMIT, 4, consecutive load grants allowed while a store waits before the store is forced ahead (≥1)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- flush  in  1  pipeline flush; kills pending/in-flight loads only
- ld_req  in  1  load request valid
- ld_addr  in  32  word-aligned load address
- ld_rmask  in  4  load byte mask, nonzero when ld_req
- ld_gnt  out  1  load accepted this cycle; requester may drop ld_req next cycle
- ld_resp  out  1  load data valid (one-cycle pulse)
- ld_rdata  out  32  load data, valid with ld_resp
- st_req  in  1  committed store ready to drain
- st_addr  in  32  word-aligned store address
- st_wmask  in  4  store byte mask, nonzero when st_req
- st_wdata  in  32  store data
- st_full  in  1  store buffer full; raises store priority
- st_gnt  out  1  store accepted this cycle
- st_resp  out  1  store written (one-cycle pulse); buffer dequeues on it
- dmem_addr  out  32  cache address
- dmem_rmask  out  4  cache read mask; nonzero marks a read request
- dmem_wmask  out  4  cache write mask; nonzero marks a write request
- dmem_wdata  out  32  cache write data
- dmem_rdata  in  32  cache read data
- dmem_resp  in  1  cache response for the outstanding request

## Operation
- States: IDLE, LOAD, STORE, LOAD_SQUASH.
- Grants are combinational, issued only in IDLE; at most one of ld_gnt/st_gnt per cycle.
- Store wins in IDLE when st_req && (st_full || starve_cnt == STARVE_LIMIT || !ld_req || flush). Otherwise load wins when ld_req && !flush.
- On grant: latch addr, mask and data into the request register. Load grant → LOAD; store grant → STORE.
- starve_cnt: +1 on each load grant while st_req=1, saturating at STARVE_LIMIT. Cleared on store grant.
- LOAD:
  - dmem_resp → ld_resp=1, ld_rdata=dmem_rdata; → IDLE.
  - flush without dmem_resp → LOAD_SQUASH.
  - flush with dmem_resp in the same cycle → ld_resp suppressed; → IDLE.
- LOAD_SQUASH: request held unchanged; on dmem_resp, ld_resp is suppressed and the state → IDLE.
- STORE: flush is ignored (the store is committed). dmem_resp → st_resp=1; → IDLE.
- dmem outputs are driven from the request register in LOAD/STORE/LOAD_SQUASH and are zero in IDLE. The request is held bit-stable until dmem_resp.
- ld_rdata is zero except when ld_resp=1.
- Reset state: IDLE, starve_cnt=0, request register 0. All outputs 0.
- rst mid-transaction abandons the request (cache is reset alongside) and produces no response pulse.

## Timing
- Grant in cycle T. dmem request is visible from T+1.
- Cache response in cycle R (≥T+1) → ld_resp/st_resp in R, same cycle.
- State returns to IDLE in R+1; the next grant is possible in R+1.
- Minimum turnaround is 2 cycles per access (grant cycle plus a 1-cycle cache).
- Load-to-use latency seen by the memory unit is 1 + cache latency.
- dmem_resp while IDLE is ignored. The verifier asserts that it never occurs.

## Structure
- arb_state_t enum (IDLE, LOAD, STORE, LOAD_SQUASH) goes in rv32i_types.
- dmem_req_t struct {addr, rmask, wmask, wdata} also goes in rv32i_types and is reused by the memory unit.
- Counter width is $clog2(STARVE_LIMIT+1).
- Single module, no sub-modules.

## Test plan
- Load only:
  - Stimulus: ld_req, addr 0x1000, rmask 4'hF; cache returns 0xDEADBEEF after 3 cycles.
  - Required: ld_gnt at T; dmem_addr 0x1000 and rmask F from T+1 through the resp cycle; ld_resp and data in the same cycle; IDLE after.
- Store priority on full:
  - Stimulus: ld_req and st_req and st_full together.
  - Required: st_gnt; dmem_wmask=st_wmask, rmask=0; st_resp on dmem_resp; load granted in the next IDLE cycle.
- Starvation:
  - Stimulus: ld_req and st_req held continuously, STARVE_LIMIT=4, 1-cycle cache.
  - Required: exactly 4 load grants, then a store grant, then starve_cnt=0.
- Flush in flight:
  - Stimulus: load granted; flush 1 cycle later; resp 2 cycles after that.
  - Required: LOAD_SQUASH; dmem request held stable; no ld_resp; IDLE after resp.
- Flush with response and during store:
  - Stimulus (a): flush coincident with dmem_resp in LOAD.
  - Required (a): ld_resp=0.
  - Stimulus (b): flush during STORE.
  - Required (b): st_resp still asserts on dmem_resp.
- Reset mid-operation:
  - Stimulus: rst asserted during STORE.
  - Required: next cycle IDLE, all outputs 0, starve_cnt=0, no st_resp.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: data-port arbiter states and the dmem request record.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    LOAD_SQUASH
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-cache port arbiter: speculative loads vs committed store drain, one request outstanding.
module dmem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_gnt,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  input  logic        st_full,
  output logic        st_gnt,
  output logic        st_resp,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  arb_state_t    state;
  dmem_req_t     req;
  logic [CW-1:0] starve_cnt;
  logic          st_win;
  logic          ld_win;

  // Grant selection; the store is forced ahead on full buffer, starvation, no load, or flush.
  always_comb begin
    st_win = 1'b0;
    ld_win = 1'b0;
    if (!rst && state == IDLE) begin
      st_win = st_req && (st_full || starve_cnt == CNT_MAX || !ld_req || flush);
      ld_win = !st_win && ld_req && !flush;
    end
    st_gnt = st_win;
    ld_gnt = ld_win;
  end

  // Response pulses and cache-side drive; reset suppresses any response in flight.
  always_comb begin
    ld_resp    = !rst && state == LOAD && dmem_resp && !flush;
    st_resp    = !rst && state == STORE && dmem_resp;
    ld_rdata   = ld_resp ? dmem_rdata : '0;
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    if (state != IDLE) begin
      dmem_addr  = req.addr;
      dmem_rmask = req.rmask;
      dmem_wmask = req.wmask;
      dmem_wdata = req.wdata;
    end
  end

  // Arbitration FSM, request register and load-priority counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req        <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st_win) begin
            req        <= '{addr: st_addr, rmask: 4'b0, wmask: st_wmask, wdata: st_wdata};
            starve_cnt <= '0;
            state      <= STORE;
          end else if (ld_win) begin
            req   <= '{addr: ld_addr, rmask: ld_rmask, wmask: 4'b0, wdata: 32'b0};
            state <= LOAD;
            if (st_req && starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end
        end
        LOAD: begin
          if (dmem_resp) begin
            state <= IDLE;
          end else if (flush) begin
            state <= LOAD_SQUASH;
          end
        end
        LOAD_SQUASH: begin
          if (dmem_resp) begin
            state <= IDLE;
          end
        end
        STORE: begin
          if (dmem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
